// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART controller types, status widths and helpers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } uartState_t;

    localparam int c_DATA_W     = 8;
    localparam int c_ERR_CNT_W  = 8;
    localparam int c_IDLE_CNT_W = 16;

    function automatic logic [c_ERR_CNT_W-1:0] satInc(input logic [c_ERR_CNT_W-1:0] value);
        return (&value) ? value : value + c_ERR_CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO, power-of-2 depth
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pushEn,
    input  logic [Width-1:0]        pushData,
    input  logic                    popEn,
    output logic [Width-1:0]        headData,
    output logic [$clog2(Depth):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int c_PTR_W = $clog2(Depth);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W+1)'(Depth);

    logic [Width-1:0]   r_mem [Depth];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL);
    assign count = r_count;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_pop  = popEn && !empty;
    assign w_push = pushEn && (!full || w_pop);

    assign headData = empty ? '0 : r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receive controller: enable FSM, RX FIFO, status, idle timeout
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int Depth         = 8,
    parameter int TimeoutCycles = 160
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    rxDone,
    input  logic                    rxErr,
    input  logic [c_DATA_W-1:0]     rxData,
    output logic [c_DATA_W-1:0]     outData,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [$clog2(Depth):0]  count,
    output logic                    overrun,
    output logic [c_ERR_CNT_W-1:0]  frameErrCount,
    output logic                    idleTimeout,
    input  logic                    clearStatus
);

    localparam int c_CNT_W = $clog2(Depth) + 1;
    localparam logic [c_IDLE_CNT_W-1:0] c_TIMEOUT = c_IDLE_CNT_W'(TimeoutCycles);

    uartState_t              r_state;
    logic                    r_overrun;
    logic [c_ERR_CNT_W-1:0]  r_frameErrCnt;
    logic [c_IDLE_CNT_W-1:0] r_idleCnt;
    logic                    r_idleTimeout;

    logic w_active;
    logic w_pushReq;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_drop;
    logic w_errEvt;
    logic w_drainDone;

    assign w_active    = (r_state == ST_ACTIVE);
    assign w_pushReq   = w_active && rxDone && !rxErr;
    assign w_pop       = outValid && outReady;
    assign w_drop      = w_pushReq && w_full && !w_pop;
    assign w_errEvt    = w_active && rxErr;
    assign w_drainDone = w_empty || ((count == c_CNT_W'(1)) && w_pop);

    assign outValid      = !w_empty;
    assign overrun       = r_overrun;
    assign frameErrCount = r_frameErrCnt;
    assign idleTimeout   = r_idleTimeout;

    uart_sync_fifo #(
        .Depth (Depth),
        .Width (c_DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .pushEn   (w_pushReq),
        .pushData (rxData),
        .popEn    (w_pop),
        .headData (outData),
        .count    (count),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_overrun     <= 1'b0;
            r_frameErrCnt <= '0;
            r_idleCnt     <= '0;
            r_idleTimeout <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!enable) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (enable) begin
                        r_state <= ST_ACTIVE;
                    end else if (w_drainDone) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Software clear wins over any status event landing in the same cycle.
            if (clearStatus) begin
                r_overrun     <= 1'b0;
                r_frameErrCnt <= '0;
            end else begin
                if (w_drop) begin
                    r_overrun <= 1'b1;
                end
                if (w_errEvt) begin
                    r_frameErrCnt <= satInc(r_frameErrCnt);
                end
            end

            // Counter parks at the threshold so each idle period yields one pulse.
            if (w_pushReq || w_empty) begin
                r_idleCnt     <= '0;
                r_idleTimeout <= 1'b0;
            end else if (w_active && (r_idleCnt != c_TIMEOUT)) begin
                r_idleCnt     <= r_idleCnt + c_IDLE_CNT_W'(1);
                r_idleTimeout <= ((r_idleCnt + c_IDLE_CNT_W'(1)) == c_TIMEOUT);
            end else begin
                r_idleTimeout <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Directed, table-driven self-checking bench for uart_rx_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int c_DEPTH = 8;
    localparam int c_TO    = 40;

    typedef struct {
        logic       en;
        logic       done;
        logic       err;
        logic [7:0] data;
        logic       rdy;
        logic       clr;
        int         expCount;
        logic       expValid;
        logic [7:0] expData;
        logic       expOvr;
        logic [7:0] expErr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic rxDone;
    logic rxErr;
    logic [7:0] rxData;
    logic [7:0] outData;
    logic outValid;
    logic outReady;
    logic [$clog2(c_DEPTH):0] count;
    logic overrun;
    logic [7:0] frameErrCount;
    logic idleTimeout;
    logic clearStatus;

    int nTests = 0;
    int nFail  = 0;
    vec_t vecs [9];

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .Depth         (c_DEPTH),
        .TimeoutCycles (c_TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .rxDone        (rxDone),
        .rxErr         (rxErr),
        .rxData        (rxData),
        .outData       (outData),
        .outValid      (outValid),
        .outReady      (outReady),
        .count         (count),
        .overrun       (overrun),
        .frameErrCount (frameErrCount),
        .idleTimeout   (idleTimeout),
        .clearStatus   (clearStatus)
    );

    task automatic check(input string name, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rxDone      = 1'b0;
        rxErr       = 1'b0;
        rxData      = 8'h00;
        clearStatus = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        rxDone = 1'b1;
        rxData = d;
        step();
        rxDone = 1'b0;
        rxData = 8'h00;
    endtask

    task automatic timeoutWindow(input string tag);
        int pulses;
        int firstAt;
        pulses  = 0;
        firstAt = -1;
        for (int k = 1; k <= c_TO + 20; k++) begin
            step();
            if (idleTimeout) begin
                pulses++;
                if (firstAt < 0) firstAt = k;
            end
        end
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_delay"}, firstAt, c_TO);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            en   done err  data   rdy  clr  cnt val  data   ovr  err
        vecs[0] = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0, 0, 1'b0,8'h00,1'b0,8'd0};
        vecs[1] = '{1'b1,1'b1,1'b0,8'h55,1'b1,1'b0, 1, 1'b1,8'h55,1'b0,8'd0};
        vecs[2] = '{1'b1,1'b1,1'b0,8'hA3,1'b1,1'b0, 1, 1'b1,8'hA3,1'b0,8'd0};
        vecs[3] = '{1'b1,1'b1,1'b0,8'h00,1'b1,1'b0, 1, 1'b1,8'h00,1'b0,8'd0};
        vecs[4] = '{1'b1,1'b0,1'b0,8'h00,1'b1,1'b0, 0, 1'b0,8'h00,1'b0,8'd0};
        vecs[5] = '{1'b1,1'b1,1'b1,8'h77,1'b1,1'b0, 0, 1'b0,8'h00,1'b0,8'd1};
        vecs[6] = '{1'b1,1'b0,1'b0,8'h00,1'b1,1'b1, 0, 1'b0,8'h00,1'b0,8'd0};
        vecs[7] = '{1'b1,1'b1,1'b0,8'h11,1'b0,1'b0, 1, 1'b1,8'h11,1'b0,8'd0};
        vecs[8] = '{1'b1,1'b0,1'b0,8'h00,1'b1,1'b0, 0, 1'b0,8'h00,1'b0,8'd0};

        reset    = 1'b1;
        enable   = 1'b0;
        outReady = 1'b0;
        quiet();
        step();
        step();
        check("rst_count", int'(count), 0);
        check("rst_valid", int'(outValid), 0);
        check("rst_data", int'(outData), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_errcnt", int'(frameErrCount), 0);
        check("rst_timeout", int'(idleTimeout), 0);
        check("rst_state", int'(dut.r_state), int'(ST_IDLE));
        reset = 1'b0;

        // Basic streaming, empty-FIFO pops, error pair and status clear.
        for (int i = 0; i < 9; i++) begin
            enable      = vecs[i].en;
            rxDone      = vecs[i].done;
            rxErr       = vecs[i].err;
            rxData      = vecs[i].data;
            outReady    = vecs[i].rdy;
            clearStatus = vecs[i].clr;
            step();
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].expCount);
            check($sformatf("vec%0d_valid", i), int'(outValid), int'(vecs[i].expValid));
            check($sformatf("vec%0d_data", i), int'(outData), int'(vecs[i].expData));
            check($sformatf("vec%0d_overrun", i), int'(overrun), int'(vecs[i].expOvr));
            check($sformatf("vec%0d_errcnt", i), int'(frameErrCount), int'(vecs[i].expErr));
        end
        quiet();

        // Overflow with outReady low, then push+pop while full.
        outReady = 1'b0;
        for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
        check("ovf_count", int'(count), 8);
        check("ovf_overrun", int'(overrun), 1);
        check("ovf_head", int'(outData), 8'h10);
        outReady = 1'b1;
        push(8'h99);
        check("ovf_pushpop_count", int'(count), 8);
        check("ovf_pushpop_head", int'(outData), 8'h11);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_pop%0d", i), int'(outData), (i < 7) ? (8'h11 + i) : 8'h99);
            step();
        end
        check("ovf_empty_count", int'(count), 0);
        check("ovf_empty_valid", int'(outValid), 0);
        clearStatus = 1'b1;
        step();
        clearStatus = 1'b0;
        check("ovf_clear", int'(overrun), 0);
        outReady = 1'b0;

        // Framing-error saturation and clear priority.
        rxErr = 1'b1;
        repeat (300) step();
        rxErr = 1'b0;
        check("err_saturate", int'(frameErrCount), 255);
        rxDone = 1'b1;
        rxErr  = 1'b1;
        rxData = 8'h5A;
        step();
        quiet();
        check("err_pair_count", int'(count), 0);
        check("err_pair_errcnt", int'(frameErrCount), 255);
        for (int i = 0; i < 8; i++) push(8'(i));
        check("err_fill_count", int'(count), 8);
        rxDone      = 1'b1;
        rxData      = 8'hFF;
        clearStatus = 1'b1;
        step();
        quiet();
        check("clr_prio_overrun", int'(overrun), 0);
        check("clr_prio_errcnt", int'(frameErrCount), 0);
        check("clr_prio_count", int'(count), 8);
        rxErr       = 1'b1;
        clearStatus = 1'b1;
        step();
        check("clr_prio_err_evt", int'(frameErrCount), 0);
        clearStatus = 1'b0;
        step();
        check("err_after_clear", int'(frameErrCount), 1);
        quiet();
        outReady = 1'b1;
        repeat (8) step();
        check("err_drain_count", int'(count), 0);
        outReady = 1'b0;

        // Idle timeout: one pulse per idle period, re-armed by a push.
        push(8'hC3);
        timeoutWindow("to_first");
        push(8'hC4);
        timeoutWindow("to_rearm");
        outReady = 1'b1;
        step();
        step();
        check("to_drain_count", int'(count), 0);
        outReady = 1'b0;

        // Drain on enable drop, re-enable with bytes pending.
        for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
        enable = 1'b0;
        step();
        check("drn_state", int'(dut.r_state), int'(ST_DRAIN));
        push(8'hEE);
        check("drn_ignore_count", int'(count), 4);
        outReady = 1'b1;
        check("drn_pop0", int'(outData), 8'hA0);
        step();
        check("drn_pop1", int'(outData), 8'hA1);
        step();
        check("drn_left_count", int'(count), 2);
        enable   = 1'b1;
        outReady = 1'b0;
        step();
        check("drn_reen_state", int'(dut.r_state), int'(ST_ACTIVE));
        check("drn_reen_count", int'(count), 2);
        push(8'hB0);
        check("drn_reen_push", int'(count), 3);
        enable   = 1'b0;
        outReady = 1'b1;
        check("drn_pop2", int'(outData), 8'hA2);
        step();
        check("drn_state2", int'(dut.r_state), int'(ST_DRAIN));
        check("drn_pop3", int'(outData), 8'hA3);
        step();
        check("drn_pop4", int'(outData), 8'hB0);
        step();
        check("drn_final_count", int'(count), 0);
        check("drn_final_state", int'(dut.r_state), int'(ST_IDLE));
        outReady = 1'b0;

        // Asynchronous reset between edges with five bytes queued.
        enable = 1'b1;
        step();
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        check("arst_pre_count", int'(count), 5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_valid", int'(outValid), 0);
        check("arst_data", int'(outData), 0);
        check("arst_state", int'(dut.r_state), int'(ST_IDLE));
        step();
        step();
        reset = 1'b0;
        step();
        check("arst_resume_count", int'(count), 0);
        push(8'h42);
        check("arst_push_count", int'(count), 1);
        check("arst_push_data", int'(outData), 8'h42);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

`default_nettype wire
